// File: rtl/alu_simd_accum_reg_if.sv
// Term/result bus between the SIMD ALU lane, the accumulator register stage and its consumer.
interface alu_simd_accum_reg_if #(
    parameter int WIDTH = 8,
    parameter int EXT_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       s_in;
    logic [1:0]             cout_in;
    logic [WIDTH-1:0]       w_fb;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH+EXT_W-1:0] result;
    logic                   ovf;

    modport master (
        output in_valid, s_in, cout_in, out_ready,
        input  in_ready, w_fb, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, s_in, cout_in, out_ready,
        output in_ready, w_fb, out_valid, result, ovf
    );
endinterface

// File: rtl/alu_simd_accum_reg.sv
// P/EXT accumulator behind the SIMD ALU lane: P feeds back as W, carry-outs extend the result.
// Optional ALU_ACC_SAT_EN: saturate RESULT to all ones when the extension overflows.
module alu_simd_accum_reg #(
    parameter int WIDTH = 8,
    parameter int EXT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    alu_simd_accum_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] p;
    logic [EXT_W-1:0] ext;
    logic [LEN_W-1:0] cnt, len_q, cnt_inc;
    logic             ovf_q, accept;
    logic [EXT_W:0]   ext_sum;

    assign bus.in_ready  = (state != HOLD);
    assign accept        = bus.in_valid & bus.in_ready;
    assign cnt_inc       = cnt + LEN_W'(1);
    assign ext_sum       = {1'b0, ext} + (EXT_W+1)'(bus.cout_in);
    // The ALU adds W combinationally, so the first term must see zero.
    assign bus.w_fb      = (state == IDLE) ? '0 : p;
    assign bus.out_valid = (state == HOLD);
    assign bus.ovf       = ovf_q;
    assign busy          = (state != IDLE);

`ifdef ALU_ACC_SAT_EN
    assign bus.result = (state == HOLD && ovf_q) ? '1 : {ext, p};
`else
    assign bus.result = {ext, p};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            ext   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            p     <= '0;
            ext   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    p     <= bus.s_in;
                    ext   <= EXT_W'(bus.cout_in);
                    cnt   <= LEN_W'(1);
                    len_q <= (len == '0) ? LEN_W'(1) : len;
                    ovf_q <= 1'b0;
                    state <= (len <= LEN_W'(1)) ? HOLD : ACC;
                end
                ACC: if (accept) begin
                    p     <= bus.s_in;
`ifdef ALU_ACC_SAT_EN
                    // Freeze EXT once it overflows; the wrap never becomes visible.
                    if (!ovf_q && !ext_sum[EXT_W]) ext <= ext_sum[EXT_W-1:0];
`else
                    ext   <= ext_sum[EXT_W-1:0];
`endif
                    ovf_q <= ovf_q | ext_sum[EXT_W];
                    cnt   <= cnt_inc;
                    if (cnt_inc == len_q) state <= HOLD;
                end
                HOLD: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_simd_accum_reg.sv
// Directed bench for alu_simd_accum_reg with an 8-bit ALU lane modelled in the loop.
module tb_alu_simd_accum_reg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy;

    logic       use_alu = 1'b0;
    logic [7:0] x = 8'h00, y = 8'h00, s_drv = 8'h00;
    logic       cin = 1'b0;
    logic [1:0] c_drv = 2'd0;
    logic [9:0] alu_sum;

    int total = 0;
    int bad = 0;

    alu_simd_accum_reg_if #(.WIDTH(8), .EXT_W(4)) bus ();

    alu_simd_accum_reg #(.WIDTH(8), .EXT_W(4), .LEN_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .len  (len),
        .busy (busy),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign alu_sum     = {2'b00, bus.w_fb} + {2'b00, x} + {2'b00, y} + {9'd0, cin};
    assign bus.s_in    = use_alu ? alu_sum[7:0] : s_drv;
    assign bus.cout_in = use_alu ? alu_sum[9:8] : c_drv;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got ov=%b ir=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, busy);
        end
        total++;
        if (bus.result !== 12'h000 || bus.w_fb !== 8'h00 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: got result=%h wfb=%h ovf=%b want 000 00 0", bus.result, bus.w_fb, bus.ovf);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_accum_alu();
        use_alu = 1'b1; x = 8'hFF; y = 8'hFF; cin = 1'b0;
        len = 8'd3;
        bus.in_valid = 1'b1;
        step();
        total++;
        if (bus.w_fb !== 8'hFE || busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL accum_term1: got wfb=%h busy=%b ov=%b want FE 1 0", bus.w_fb, busy, bus.out_valid);
        end
        len = 8'd7;  // ignored mid-accumulation
        step();
        total++;
        if (bus.w_fb !== 8'hFC || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL accum_term2: got wfb=%h ov=%b want FC 0", bus.w_fb, bus.out_valid);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 12'h5FA || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL accum_result: got ov=%b result=%h ovf=%b want 1 5FA 0", bus.out_valid, bus.result, bus.ovf);
        end
    endtask

    task automatic test_backpressure();
        // Still in HOLD from the previous task with in_valid asserted.
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 12'h5FA) begin
                bad++;
                $display("FAIL bp_hold%0d: got ov=%b ir=%b result=%h want 1 0 5FA", i, bus.out_valid, bus.in_ready, bus.result);
            end
        end
        bus.in_valid = 1'b0;
        use_alu = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.w_fb !== 8'h00) begin
            bad++;
            $display("FAIL bp_release: got ov=%b busy=%b ir=%b wfb=%h want 0 0 1 00", bus.out_valid, busy, bus.in_ready, bus.w_fb);
        end
    endtask

    task automatic test_len0();
        len = 8'd0;
        s_drv = 8'h12; c_drv = 2'd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 12'h312 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL len0: got ov=%b result=%h ovf=%b want 1 312 0", bus.out_valid, bus.result, bus.ovf);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [11:0] exp;
`ifdef ALU_ACC_SAT_EN
        exp = 12'hFFF;
`else
        exp = 12'h240;
`endif
        len = 8'd6;
        c_drv = 2'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_drv = (i == 5) ? 8'h40 : 8'h01;
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1 || bus.result !== exp) begin
            bad++;
            $display("FAIL overflow: got ov=%b ovf=%b result=%h want 1 1 %h", bus.out_valid, bus.ovf, bus.result, exp);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_clr();
        len = 8'd4;
        bus.in_valid = 1'b1;
        s_drv = 8'h10; c_drv = 2'd1;
        step();
        s_drv = 8'h20; c_drv = 2'd2;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (busy !== 1'b0 || bus.w_fb !== 8'h00 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_idle: got busy=%b wfb=%h ir=%b ov=%b want 0 00 1 0", busy, bus.w_fb, bus.in_ready, bus.out_valid);
        end
        s_drv = 8'h11; c_drv = 2'd1; step();
        s_drv = 8'h22; c_drv = 2'd2; step();
        s_drv = 8'h33; c_drv = 2'd0; step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.w_fb !== 8'h33) begin
            bad++;
            $display("FAIL clr_count: got ov=%b wfb=%h want 0 33", bus.out_valid, bus.w_fb);
        end
        s_drv = 8'h44; c_drv = 2'd3; step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 12'h644 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL clr_result: got ov=%b result=%h ovf=%b want 1 644 0", bus.out_valid, bus.result, bus.ovf);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        len = 8'd4;
        s_drv = 8'h55; c_drv = 2'd2;
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.w_fb !== 8'h55) begin
            bad++;
            $display("FAIL areset_pre: got busy=%b wfb=%h want 1 55", busy, bus.w_fb);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 12'h000 || bus.w_fb !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL areset: got ov=%b ir=%b result=%h wfb=%h busy=%b want 0 1 000 00 0",
                     bus.out_valid, bus.in_ready, bus.result, bus.w_fb, busy);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_accum_alu();
        test_backpressure();
        test_len0();
        test_overflow();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_simd_accum_reg.md
Name: alu_simd_accum_reg

Overview:
- Downstream stage of the SIMD-width ALU lane (S = W + X + Y + CIN, with a 2-bit COUT).
- Registers the lane sum into a P register and feeds P back as the ALU W operand.
- Accumulates the ALU carry-outs in an extension counter, giving a full-precision result over a programmable number of terms.
- Presents the result through a valid/ready handshake to the next pipeline stage.

Parameters:
- Width, 8, lane width; must match the ALU lane width.
- EXT_W, 4, width of the carry-extension counter (upper result bits).
- LEN_W, 8, width of the term-count input.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous abort/clear; priority over all other inputs except RST_N.
- LEN  input  LEN_W  terms per accumulation; sampled on the first accepted term; 0 is treated as 1.
- IN_VALID  input  1  S_IN/COUT_IN carry a valid term.
- IN_READY  output  1  block accepts a term this cycle.
- S_IN  input  Width  ALU sum S.
- COUT_IN  input  2  ALU carry-out COUT (range 0..3).
- W_FB  output  Width  feedback to the ALU W input.
- OUT_VALID  output  1  RESULT valid.
- OUT_READY  input  1  consumer accepts RESULT.
- RESULT  output  Width+EXT_W  {EXT, P}.
- OVF  output  1  extension overflow flag for the current result.
- BUSY  output  1  state is not IDLE.

Behaviour:
- States: IDLE, ACC, HOLD. Reset values: state=IDLE, P=0, EXT=0, cnt=0, len_q=0, OVF=0; hence OUT_VALID=0, IN_READY=1, BUSY=0, RESULT=0, W_FB=0.
- Term accept: IN_VALID & IN_READY. IN_READY = (state != HOLD).
- W_FB is combinational. It is 0 in IDLE and P in ACC. In HOLD it is also P, but don't-care because no term is accepted.
- The ALU is combinational, so S_IN/COUT_IN in the accept cycle already include W_FB.
- IDLE + accept:
  - P<=S_IN, EXT<=COUT_IN (zero-extended), cnt<=1, len_q<=max(LEN,1), OVF<=0.
  - If len_q would be 1, go to HOLD; otherwise go to ACC.
- ACC + accept:
  - P<=S_IN; {carry,EXT}<=EXT+COUT_IN; OVF<=OVF|carry; cnt<=cnt+1.
  - When cnt+1 == len_q, go to HOLD.
- ACC without accept: hold all state (stall allowed indefinitely).
- HOLD: OUT_VALID=1; RESULT and OVF stable. When OUT_READY=1, go to IDLE next cycle. There is a one-cycle bubble before the next accumulation; P/EXT are not cleared, but RESULT is don't-care in IDLE.
- Latency: RESULT is valid the cycle after the last term is accepted.
- Throughput: LEN+1 cycles per result when OUT_READY=1.
- EXT arithmetic is modulo 2^EXT_W; the carry sets OVF, which is sticky until the next first term.
- CLR=1: next state IDLE, P=0, EXT=0, cnt=0, OVF=0; any term presented that cycle is discarded.
- CLR and OUT_READY together in HOLD: CLR wins; the result is dropped.
- RST_N low mid-accumulation: immediate asynchronous return to reset values; the partial result is lost.
- LEN changes during ACC: ignored; len_q is used.

Optional Feature:
- Macro: ALU_ACC_SAT_EN.
- Defined: when OVF=1 in HOLD, RESULT is forced to all ones. OVF is still reported. EXT stops updating after overflow; EXT wrap-around is internal only.
- Undefined: RESULT is the wrapped {EXT,P}; OVF is informational only.

Test Plan:
- Reset: RST_N=0 asynchronously mid-ACC -> OUT_VALID=0, IN_READY=1, RESULT=0, W_FB=0 with no clock edge required.
- Accumulate with a real ALU in loop, Width=8, EXT_W=4, LEN=3, X=Y=0xFF, CIN=0:
  - terms (S,COUT) = (FE,1), (FC,2), (FA,2);
  - RESULT=0x5FA one cycle after the 3rd accept, OVF=0.
- LEN=0: single term S=0x12, COUT=3 -> HOLD next cycle, RESULT=0x312.
- Backpressure: HOLD with OUT_READY=0 for 5 cycles -> RESULT stable, IN_READY=0, IN_VALID ignored. OUT_READY=1 -> IDLE next cycle.
- Overflow: LEN=6, each term COUT=3, last S=0x40:
  - EXT total 18, so OVF=1 and RESULT=0x240 (wrapped);
  - with ALU_ACC_SAT_EN, RESULT=0xFFF.
- CLR on the 2nd of 4 terms -> IDLE, W_FB=0; the next term starts fresh with cnt=1 and the correct final sum.
